div_scheduler: RTL and testbench

DIV_SCHEDULER -- requirements
Module: div_scheduler

---
 rtl/div_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 18 +
 rtl/div_scheduler.sv | 165 ++++++++++++++++
 tb/tb_div_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider scheduler: FSM encoding, response status codes, default width.
package div_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StIssue = 2'd1;
    localparam state_t StBusy  = 2'd2;
    localparam state_t StResp  = 2'd3;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK      = 2'b00;
    localparam status_t ST_DIV0    = 2'b01;
    localparam status_t ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; on a tie the port that did not win last time is granted.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/div_scheduler.sv
// Shares one multi-cycle divider between two requesters, one transaction in flight,
// short-circuiting divide-by-zero and aborting divider runs that exceed TIMEOUT cycles.
module div_scheduler
    import div_pkg::*;
#(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned WIDTH   = DefaultWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_dividend0,
    input  logic [WIDTH-1:0] req_dividend1,
    input  logic [WIDTH-1:0] req_divisor0,
    input  logic [WIDTH-1:0] req_divisor1,
    output logic             core_start,
    output logic [WIDTH-1:0] core_dividend,
    output logic [WIDTH-1:0] core_divisor,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_quotient,
    input  logic [WIDTH-1:0] core_remainder,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_quotient,
    output logic [WIDTH-1:0] resp_remainder,
    output logic [1:0]       resp_status
);

    localparam int unsigned      CntW       = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              core_start_q, core_start_d;
    logic [WIDTH-1:0]  core_dividend_q, core_dividend_d;
    logic [WIDTH-1:0]  core_divisor_q, core_divisor_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_id_q, resp_id_d;
    logic [WIDTH-1:0]  resp_quotient_q, resp_quotient_d;
    logic [WIDTH-1:0]  resp_remainder_q, resp_remainder_d;
    status_t           resp_status_q, resp_status_d;

    logic [1:0]        grant;
    logic              accept;
    logic              sel_id;
    logic [WIDTH-1:0]  sel_dividend;
    logic [WIDTH-1:0]  sel_divisor;

    rr_arbiter2 u_arb (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Gated by reset so nothing looks acceptable while the block is held in reset.
    assign req_ready    = (state_q == StIdle && reset) ? grant : 2'b00;
    assign accept       = |(req_valid & req_ready);
    assign sel_id       = grant[1];
    assign sel_dividend = sel_id ? req_dividend1 : req_dividend0;
    assign sel_divisor  = sel_id ? req_divisor1  : req_divisor0;

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        cnt_d            = cnt_q;
        core_start_d     = 1'b0;
        core_dividend_d  = core_dividend_q;
        core_divisor_d   = core_divisor_q;
        resp_valid_d     = resp_valid_q;
        resp_id_d        = resp_id_q;
        resp_quotient_d  = resp_quotient_q;
        resp_remainder_d = resp_remainder_q;
        resp_status_d    = resp_status_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    last_grant_d    = sel_id;
                    resp_id_d       = sel_id;
                    core_dividend_d = sel_dividend;
                    core_divisor_d  = sel_divisor;
                    if (sel_divisor == '0) begin
                        state_d          = StResp;
                        resp_valid_d     = 1'b1;
                        resp_quotient_d  = '1;
                        resp_remainder_d = sel_dividend;
                        resp_status_d    = ST_DIV0;
                    end else begin
                        state_d      = StIssue;
                        core_start_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StBusy;
            end
            StBusy: begin
                cnt_d = cnt_q + CntW'(1);
                // Completion takes priority over a timeout landing on the same edge.
                if (core_done) begin
                    state_d          = StResp;
                    resp_valid_d     = 1'b1;
                    resp_quotient_d  = core_quotient;
                    resp_remainder_d = core_remainder;
                    resp_status_d    = ST_OK;
                end else if (cnt_d == TimeoutCnt) begin
                    state_d          = StResp;
                    resp_valid_d     = 1'b1;
                    resp_quotient_d  = '0;
                    resp_remainder_d = '0;
                    resp_status_d    = ST_TIMEOUT;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= StIdle;
            last_grant_q     <= 1'b1;
            cnt_q            <= '0;
            core_start_q     <= 1'b0;
            core_dividend_q  <= '0;
            core_divisor_q   <= '0;
            resp_valid_q     <= 1'b0;
            resp_id_q        <= 1'b0;
            resp_quotient_q  <= '0;
            resp_remainder_q <= '0;
            resp_status_q    <= ST_OK;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            cnt_q            <= cnt_d;
            core_start_q     <= core_start_d;
            core_dividend_q  <= core_dividend_d;
            core_divisor_q   <= core_divisor_d;
            resp_valid_q     <= resp_valid_d;
            resp_id_q        <= resp_id_d;
            resp_quotient_q  <= resp_quotient_d;
            resp_remainder_q <= resp_remainder_d;
            resp_status_q    <= resp_status_d;
        end
    end

    assign core_start     = core_start_q;
    assign core_dividend  = core_dividend_q;
    assign core_divisor   = core_divisor_q;
    assign resp_valid     = resp_valid_q;
    assign resp_id        = resp_id_q;
    assign resp_quotient  = resp_quotient_q;
    assign resp_remainder = resp_remainder_q;
    assign resp_status    = resp_status_q;

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler; the bench plays the divider core with hand-computed results.
module tb_div_scheduler;
    import div_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned TO = 40;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req_dividend0, req_dividend1, req_divisor0, req_divisor1;
    logic         core_start;
    logic [W-1:0] core_dividend, core_divisor;
    logic         core_done;
    logic [W-1:0] core_quotient, core_remainder;
    logic         resp_valid, resp_ready, resp_id;
    logic [W-1:0] resp_quotient, resp_remainder;
    logic [1:0]   resp_status;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    div_scheduler #(.TIMEOUT(TO), .WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dividend0  (req_dividend0),
        .req_dividend1  (req_dividend1),
        .req_divisor0   (req_divisor0),
        .req_divisor1   (req_divisor1),
        .core_start     (core_start),
        .core_dividend  (core_dividend),
        .core_divisor   (core_divisor),
        .core_done      (core_done),
        .core_quotient  (core_quotient),
        .core_remainder (core_remainder),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_status    (resp_status)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Drive request valids at a negedge, check the grant, and step over the accepting edge.
    task automatic request(input logic [1:0] valid, input logic [1:0] exp_ready, input string tag);
        req_valid = valid;
        #1;
        check_eq({tag, ".ready"}, 32'(req_ready), 32'(exp_ready));
        @(negedge clk);
    endtask

    // Called at the negedge after accept: core_start must be up now, done pulses lat cycles later.
    task automatic core_run(input string tag, input int lat, input logic [31:0] q,
                            input logic [31:0] r);
        check_eq({tag, ".start"}, 32'(core_start), 32'd1);
        @(negedge clk);
        check_eq({tag, ".pulse"}, 32'(core_start), 32'd0);
        repeat (lat - 1) @(negedge clk);
        check_eq({tag, ".early"}, 32'(resp_valid), 32'd0);
        core_done      = 1'b1;
        core_quotient  = q;
        core_remainder = r;
        @(negedge clk);
        core_done      = 1'b0;
        core_quotient  = '0;
        core_remainder = '0;
    endtask

    task automatic expect_resp(input string tag, input logic id, input logic [31:0] q,
                               input logic [31:0] r, input logic [1:0] st);
        check_eq({tag, ".valid"}, 32'(resp_valid), 32'd1);
        check_eq({tag, ".id"}, 32'(resp_id), 32'(id));
        check_eq({tag, ".quot"}, resp_quotient, q);
        check_eq({tag, ".rem"}, resp_remainder, r);
        check_eq({tag, ".status"}, 32'(resp_status), 32'(st));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq({tag, ".drain"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic do_reset();
        req_valid  = 2'b00;
        resp_ready = 1'b0;
        core_done  = 1'b0;
        reset      = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 2'b00;
        resp_ready = 1'b0;
        core_done = 1'b0;
        core_quotient = '0;
        core_remainder = '0;
        req_dividend0 = '0;
        req_dividend1 = '0;
        req_divisor0 = '0;
        req_divisor1 = '0;
        #1 reset = 1'b0;
        req_valid = 2'b11;
        #1;
        check_eq("rst.ready", 32'(req_ready), 32'd0);
        check_eq("rst.start", 32'(core_start), 32'd0);
        check_eq("rst.valid", 32'(resp_valid), 32'd0);
        check_eq("rst.id", 32'(resp_id), 32'd0);
        check_eq("rst.quot", resp_quotient, 32'd0);
        check_eq("rst.rem", resp_remainder, 32'd0);
        check_eq("rst.status", 32'(resp_status), 32'd0);
        check_eq("rst.cdvd", core_dividend, 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("idle.ready", 32'(req_ready), 32'd0);

        // 136 / 4 with a 33-cycle core
        req_dividend0 = 136;
        req_divisor0  = 4;
        request(2'b01, 2'b01, "t1");
        check_eq("t1.busyready", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        check_eq("t1.cdvd", core_dividend, 32'd136);
        check_eq("t1.cdvs", core_divisor, 32'd4);
        core_run("t1", 33, 32'd34, 32'd0);
        expect_resp("t1", 1'b0, 32'd34, 32'd0, ST_OK);

        // Tie after reset: port 0, then port 1, then port 0 again
        do_reset();
        req_dividend0 = 100;
        req_divisor0  = 7;
        req_dividend1 = 50;
        req_divisor1  = 5;
        request(2'b11, 2'b01, "t2a");
        check_eq("t2a.cdvd", core_dividend, 32'd100);
        core_run("t2a", 3, 32'd14, 32'd2);
        check_eq("t2a.ready_busy", 32'(req_ready), 32'd0);
        expect_resp("t2a", 1'b0, 32'd14, 32'd2, ST_OK);
        check_eq("t2b.ready", 32'(req_ready), 32'd2);
        @(negedge clk);
        check_eq("t2b.cdvd", core_dividend, 32'd50);
        core_run("t2b", 5, 32'd10, 32'd0);
        expect_resp("t2b", 1'b1, 32'd10, 32'd0, ST_OK);
        check_eq("t2c.ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        core_run("t2c", 1, 32'd14, 32'd2);
        expect_resp("t2c", 1'b0, 32'd14, 32'd2, ST_OK);

        // Divide by zero on port 1: response next cycle, no core launch
        req_dividend1 = 77;
        req_divisor1  = 0;
        request(2'b10, 2'b10, "t3");
        req_valid = 2'b00;
        check_eq("t3.nostart", 32'(core_start), 32'd0);
        expect_resp("t3", 1'b1, 32'hFFFF_FFFF, 32'd77, ST_DIV0);

        // Core never answers: timeout after 40 busy cycles, stray done ignored
        req_dividend0 = 1000;
        req_divisor0  = 3;
        request(2'b01, 2'b01, "t4");
        req_valid = 2'b00;
        check_eq("t4.start", 32'(core_start), 32'd1);
        repeat (TO) @(negedge clk);
        check_eq("t4.before", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check_eq("t4.status0", 32'(resp_status), 32'(ST_TIMEOUT));
        core_done      = 1'b1;
        core_quotient  = 5;
        core_remainder = 1;
        @(negedge clk);
        core_done = 1'b0;
        check_eq("t4.stray_q", resp_quotient, 32'd0);
        expect_resp("t4", 1'b0, 32'd0, 32'd0, ST_TIMEOUT);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
        check_eq("t4.idle_done", 32'(resp_valid), 32'd0);
        check_eq("t4.idle_start", 32'(core_start), 32'd0);

        // Done on the very cycle the counter hits TIMEOUT: done wins
        req_dividend1 = 45;
        req_divisor1  = 9;
        request(2'b10, 2'b10, "t5");
        req_valid = 2'b00;
        core_run("t5", TO, 32'd5, 32'd0);
        expect_resp("t5", 1'b1, 32'd5, 32'd0, ST_OK);

        // Back-pressure on the response for 10 cycles
        req_dividend0 = 20;
        req_divisor0  = 6;
        request(2'b01, 2'b01, "t6");
        req_valid = 2'b00;
        core_run("t6", 2, 32'd3, 32'd2);
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("t6.hold_valid", 32'(resp_valid), 32'd1);
            check_eq("t6.hold_quot", resp_quotient, 32'd3);
            check_eq("t6.hold_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        expect_resp("t6", 1'b0, 32'd3, 32'd2, ST_OK);
        check_eq("t6.rel_ready", 32'(req_ready), 32'd2);
        req_valid = 2'b00;

        // Reset while busy abandons the transaction
        req_dividend1 = 9;
        req_divisor1  = 2;
        request(2'b10, 2'b10, "t7");
        req_valid = 2'b00;
        check_eq("t7.start", 32'(core_start), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("t7.rst_start", 32'(core_start), 32'd0);
        check_eq("t7.rst_valid", 32'(resp_valid), 32'd0);
        check_eq("t7.rst_cdvd", core_dividend, 32'd0);
        check_eq("t7.rst_id", 32'(resp_id), 32'd0);
        check_eq("t7.rst_status", 32'(resp_status), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        core_done = 1'b1;
        core_quotient = 4;
        @(negedge clk);
        core_done = 1'b0;
        core_quotient = '0;
        @(negedge clk);
        check_eq("t7.stray", 32'(resp_valid), 32'd0);
        req_dividend0 = 81;
        req_divisor0  = 9;
        request(2'b01, 2'b01, "t7b");
        req_valid = 2'b00;
        core_run("t7b", 4, 32'd9, 32'd0);
        expect_resp("t7b", 1'b0, 32'd9, 32'd0, ST_OK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
